// File: rtl/icb_cfg_init_if.sv
// Bundle of request/response handshake and ICB strobe signals for icb_cfg_init.
// master = the initiator core, slave = requester plus ICB config slave side.
interface icb_cfg_init_if #(
    parameter int aw = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [aw-1:0] req_adr;
    logic [31:0]   req_wdat;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdat;
    logic          rsp_err;
    logic          icb_wr;
    logic [aw-1:0] icb_wadr;
    logic [31:0]   icb_wdat;
    logic          icb_wack;
    logic          icb_rd;
    logic [aw-1:0] icb_radr;
    logic [31:0]   icb_rdat;
    logic          icb_rack;

    modport master (
        input  req_valid, req_we, req_adr, req_wdat, rsp_ready,
        input  icb_wack, icb_rdat, icb_rack,
        output req_ready, rsp_valid, rsp_rdat, rsp_err,
        output icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr
    );

    modport slave (
        output req_valid, req_we, req_adr, req_wdat, rsp_ready,
        output icb_wack, icb_rdat, icb_rack,
        input  req_ready, rsp_valid, rsp_rdat, rsp_err,
        input  icb_wr, icb_wadr, icb_wdat, icb_rd, icb_radr
    );
endinterface

// File: rtl/icb_cfg_init.sv
// Single-outstanding ICB initiator: one register access per request, with an
// ack timeout that aborts the strobe and reports an error response.
module icb_cfg_init #(
    parameter int aw     = 8,
    parameter int TO_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    icb_cfg_init_if.master bus
);
    typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [aw-1:0] adr_q, adr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          icb_wr_q, icb_wr_d;
    logic          icb_rd_q, icb_rd_d;
    logic          rsp_valid_q, rsp_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            icb_wr_q    <= 1'b0;
            icb_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rdat_q      <= rdat_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            icb_wr_q    <= icb_wr_d;
            icb_rd_q    <= icb_rd_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    adr_d   = bus.req_adr;
                    wdat_d  = bus.req_wdat;
                    timer_d = '0;
                    state_d = bus.req_we ? WR : RD;
                end
            end
            WR: begin
                // A same-cycle ack takes priority over the timeout abort.
                if (bus.icb_wack) begin
                    state_d = RSP;
                    rdat_d  = '0;
                    err_d   = 1'b0;
                end else if (timer_q == TO_LAST) begin
                    state_d = RSP;
                    rdat_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RD: begin
                if (bus.icb_rack) begin
                    state_d = RSP;
                    rdat_d  = bus.icb_rdat;
                    err_d   = 1'b0;
                end else if (timer_q == TO_LAST) begin
                    state_d = RSP;
                    rdat_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        req_ready_d = (state_d == IDLE);
        icb_wr_d    = (state_d == WR);
        icb_rd_d    = (state_d == RD);
        rsp_valid_d = (state_d == RSP);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdat  = rdat_q;
    assign bus.rsp_err   = err_q;
    assign bus.icb_wr    = icb_wr_q;
    assign bus.icb_wadr  = adr_q;
    assign bus.icb_wdat  = wdat_q;
    assign bus.icb_rd    = icb_rd_q;
    assign bus.icb_radr  = adr_q;
endmodule
